// File: rtl/riscv_commit_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : riscv_commit_scoreboard
// Brief    : In-order golden-trace checker for the core's register writeback
//            stream, with first-error capture, watchdog and end-of-program test.
// Revision : 1.0
// ============================================================================
module riscv_commit_scoreboard #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 32,
  parameter logic [XLEN-1:0] END_PC       = 'h080,
  parameter int              TIMEOUT      = 64,
  parameter bit              CHECK_PC     = 1'b1,
  parameter bit              STOP_ON_FAIL = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     exp_count,
  input  logic                       exp_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   exp_wr_addr,
  input  logic [XLEN-1:0]            exp_wr_pc,
  input  logic [4:0]                 exp_wr_rd,
  input  logic [XLEN-1:0]            exp_wr_data,
  input  logic [XLEN-1:0]            pc,
  input  logic                       regWrite,
  input  logic [4:0]                 rd_addr,
  input  logic [XLEN-1:0]            write_back_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH):0]     match_count,
  output logic [$clog2(DEPTH):0]     mismatch_count,
  output logic [$clog2(DEPTH)-1:0]   err_index,
  output logic [XLEN-1:0]            err_pc,
  output logic [XLEN-1:0]            err_exp_data,
  output logic [XLEN-1:0]            err_got_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT) + 1;

  localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_max   = '1;
  localparam logic [WW-1:0] c_wdog_last = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [AW:0]     r_index, w_index_next;
  logic [AW:0]     r_exp_count, w_exp_count_next;
  logic [WW-1:0]   r_wdog, w_wdog_next;
  logic            r_fail, w_fail_next;
  logic            r_timeout, w_timeout_next;
  logic            r_pass, w_pass_next;
  logic [AW:0]     r_match_count, w_match_count_next;
  logic [AW:0]     r_mismatch_count, w_mismatch_count_next;
  logic [AW-1:0]   r_err_index, w_err_index_next;
  logic [XLEN-1:0] r_err_pc, w_err_pc_next;
  logic [XLEN-1:0] r_err_exp_data, w_err_exp_data_next;
  logic [XLEN-1:0] r_err_got_data, w_err_got_data_next;

  // Expected-commit table; deliberately not reset, it is reloaded before use.
  logic [XLEN-1:0] r_tab_pc   [DEPTH];
  logic [4:0]      r_tab_rd   [DEPTH];
  logic [XLEN-1:0] r_tab_data [DEPTH];

  always_ff @(posedge clk) begin
    if (exp_wr_en && (r_state != ST_RUN)) begin
      r_tab_pc[exp_wr_addr]   <= exp_wr_pc;
      r_tab_rd[exp_wr_addr]   <= exp_wr_rd;
      r_tab_data[exp_wr_addr] <= exp_wr_data;
    end
  end

  logic [XLEN-1:0] w_entry_pc;
  logic [4:0]      w_entry_rd;
  logic [XLEN-1:0] w_entry_data;
  logic            w_commit;
  logic            w_match;
  logic [AW:0]     w_index_inc;
  logic [AW:0]     w_count_clamped;

  assign w_entry_pc      = r_tab_pc[r_index[AW-1:0]];
  assign w_entry_rd      = r_tab_rd[r_index[AW-1:0]];
  assign w_entry_data    = r_tab_data[r_index[AW-1:0]];
  assign w_commit        = regWrite && (rd_addr != 5'd0);
  assign w_match         = (rd_addr == w_entry_rd) && (write_back_data == w_entry_data) &&
                           (!CHECK_PC || (pc == w_entry_pc));
  assign w_index_inc     = r_index + 1'b1;
  assign w_count_clamped = (exp_count > c_depth) ? c_depth : exp_count;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    return (v == c_cnt_max) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_state_next          = r_state;
    w_index_next          = r_index;
    w_exp_count_next      = r_exp_count;
    w_wdog_next           = r_wdog;
    w_fail_next           = r_fail;
    w_timeout_next        = r_timeout;
    w_pass_next           = r_pass;
    w_match_count_next    = r_match_count;
    w_mismatch_count_next = r_mismatch_count;
    w_err_index_next      = r_err_index;
    w_err_pc_next         = r_err_pc;
    w_err_exp_data_next   = r_err_exp_data;
    w_err_got_data_next   = r_err_got_data;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_index_next          = '0;
          w_exp_count_next      = w_count_clamped;
          w_wdog_next           = '0;
          w_fail_next           = 1'b0;
          w_timeout_next        = 1'b0;
          w_pass_next           = 1'b0;
          w_match_count_next    = '0;
          w_mismatch_count_next = '0;
          w_err_index_next      = '0;
          w_err_pc_next         = '0;
          w_err_exp_data_next   = '0;
          w_err_got_data_next   = '0;
          if (w_count_clamped == '0) begin
            w_state_next = ST_DONE;
            w_pass_next  = 1'b1;
          end else begin
            w_state_next = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (w_commit) begin
          w_wdog_next  = '0;
          w_index_next = w_index_inc;
          if (w_match) begin
            w_match_count_next = sat_inc(r_match_count);
          end else begin
            w_mismatch_count_next = sat_inc(r_mismatch_count);
            w_fail_next           = 1'b1;
            // A zero mismatch count means this is the first error of the run.
            if (r_mismatch_count == '0) begin
              w_err_index_next    = r_index[AW-1:0];
              w_err_pc_next       = pc;
              w_err_exp_data_next = w_entry_data;
              w_err_got_data_next = write_back_data;
            end
          end
          if (w_index_inc == r_exp_count) begin
            w_state_next = ST_DONE;
          end else if (!w_match && STOP_ON_FAIL) begin
            w_state_next = ST_DONE;
          end else if ((pc == END_PC) && (w_index_inc < r_exp_count)) begin
            w_fail_next  = 1'b1;
            w_state_next = ST_DONE;
          end
        end else if (pc == END_PC) begin
          w_fail_next  = 1'b1;
          w_state_next = ST_DONE;
        end else if (r_wdog == c_wdog_last) begin
          w_timeout_next = 1'b1;
          w_fail_next    = 1'b1;
          w_state_next   = ST_DONE;
        end else begin
          w_wdog_next = r_wdog + 1'b1;
        end

        if (w_state_next == ST_DONE) begin
          w_pass_next = !w_fail_next;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_index          <= '0;
      r_exp_count      <= '0;
      r_wdog           <= '0;
      r_fail           <= 1'b0;
      r_timeout        <= 1'b0;
      r_pass           <= 1'b0;
      r_match_count    <= '0;
      r_mismatch_count <= '0;
      r_err_index      <= '0;
      r_err_pc         <= '0;
      r_err_exp_data   <= '0;
      r_err_got_data   <= '0;
    end else begin
      r_state          <= w_state_next;
      r_index          <= w_index_next;
      r_exp_count      <= w_exp_count_next;
      r_wdog           <= w_wdog_next;
      r_fail           <= w_fail_next;
      r_timeout        <= w_timeout_next;
      r_pass           <= w_pass_next;
      r_match_count    <= w_match_count_next;
      r_mismatch_count <= w_mismatch_count_next;
      r_err_index      <= w_err_index_next;
      r_err_pc         <= w_err_pc_next;
      r_err_exp_data   <= w_err_exp_data_next;
      r_err_got_data   <= w_err_got_data_next;
    end
  end

  assign busy           = (r_state == ST_RUN);
  assign done           = (r_state == ST_DONE);
  assign pass           = r_pass;
  assign fail           = r_fail;
  assign timeout        = r_timeout;
  assign match_count    = r_match_count;
  assign mismatch_count = r_mismatch_count;
  assign err_index      = r_err_index;
  assign err_pc         = r_err_pc;
  assign err_exp_data   = r_err_exp_data;
  assign err_got_data   = r_err_got_data;

endmodule
`default_nettype wire
